// File: rtl/activity_led_bank.sv
// Multi-channel activity LED driver: activity flashes with forced gaps, shared blink, steady/off.
// Optional global PWM dimming (dim port) when ACTLED_DIM_EN is defined.
module activity_led_bank #(
    parameter int unsigned         CHANNELS = 4,
    parameter logic [15:0]         CLK_MHZ  = 16'd50,
    parameter logic [CHANNELS-1:0] LED_POL  = {CHANNELS{1'b0}}
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   signal,
    input  logic [15:0]           msec,
    input  logic [2*CHANNELS-1:0] mode,
`ifdef ACTLED_DIM_EN
    input  logic [3:0]            dim,
`endif
    output logic [CHANNELS-1:0]   led,
    output logic                  busy
);

    localparam logic [19:0] PreMax = 20'(32'(CLK_MHZ) * 32'd1000 - 32'd1);

    localparam logic [1:0] ModeOff   = 2'b00;
    localparam logic [1:0] ModeAct   = 2'b01;
    localparam logic [1:0] ModeBlink = 2'b10;
    localparam logic [1:0] ModeOn    = 2'b11;

    typedef enum logic [1:0] {StIdle, StOn, StGap} act_state_e;

    logic [CHANNELS-1:0]   sync1_q, sync2_q, prev_q, edges;
    logic [19:0]           pre_q;
    logic                  tick;
    logic [15:0]           msec_eff;
    logic [15:0]           blink_cnt_q, blink_cnt_d;
    logic                  phase_q, phase_d;
    logic [2*CHANNELS-1:0] mode_q;
    act_state_e            state_q [CHANNELS];
    act_state_e            state_d [CHANNELS];
    logic [15:0]           cnt_q   [CHANNELS];
    logic [15:0]           cnt_d   [CHANNELS];
    logic [CHANNELS-1:0]   pend_q, pend_d;
    logic [CHANNELS-1:0]   lit_d, led_d, led_q;

    assign tick     = (pre_q == PreMax);
    assign msec_eff = (msec == 16'd0) ? 16'd1 : msec;
    assign edges    = sync2_q ^ prev_q;

    always_comb begin
        blink_cnt_d = blink_cnt_q;
        phase_d     = phase_q;
        if (tick) begin
            // >= keeps the counter sane if msec shrinks below the current count
            if (blink_cnt_q >= msec_eff - 16'd1) begin
                blink_cnt_d = 16'd0;
                phase_d     = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        lit_d  = '0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            // A fresh mode (or any non-activity mode) parks the channel in idle.
            if (mode[2*i +: 2] != mode_q[2*i +: 2] || mode[2*i +: 2] != ModeAct) begin
                state_d[i] = StIdle;
                cnt_d[i]   = 16'd0;
                pend_d[i]  = 1'b0;
            end else begin
                case (state_q[i])
                    StIdle: begin
                        if (edges[i]) begin
                            state_d[i] = StOn;
                            cnt_d[i]   = msec_eff;
                        end
                    end
                    StOn: begin
                        if (edges[i]) pend_d[i] = 1'b1;
                        if (tick) begin
                            if (cnt_q[i] <= 16'd1) begin
                                state_d[i] = StGap;
                                cnt_d[i]   = msec_eff;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 16'd1;
                            end
                        end
                    end
                    StGap: begin
                        if (edges[i]) pend_d[i] = 1'b1;
                        if (tick) begin
                            if (cnt_q[i] <= 16'd1) begin
                                if (pend_q[i] || edges[i]) begin
                                    state_d[i] = StOn;
                                    cnt_d[i]   = msec_eff;
                                end else begin
                                    state_d[i] = StIdle;
                                    cnt_d[i]   = 16'd0;
                                end
                                pend_d[i] = 1'b0;
                            end else begin
                                cnt_d[i] = cnt_q[i] - 16'd1;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = StIdle;
                        cnt_d[i]   = 16'd0;
                        pend_d[i]  = 1'b0;
                    end
                endcase
            end
            // Next-state lit feeds the output register so edge-to-LED stays at 3 cycles.
            case (mode[2*i +: 2])
                ModeOff:   lit_d[i] = 1'b0;
                ModeAct:   lit_d[i] = (state_d[i] == StOn);
                ModeBlink: lit_d[i] = phase_d;
                ModeOn:    lit_d[i] = 1'b1;
                default:   lit_d[i] = 1'b0;
            endcase
        end
    end

`ifdef ACTLED_DIM_EN
    logic [3:0] pwm_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pwm_q <= 4'd0;
        else        pwm_q <= pwm_q + 4'd1;
    end

    assign led_d = (lit_d & {CHANNELS{pwm_q < dim}}) ^ LED_POL;
`else
    assign led_d = lit_d ^ LED_POL;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            prev_q      <= '0;
            pre_q       <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            mode_q      <= '0;
            pend_q      <= '0;
            led_q       <= LED_POL;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= StIdle;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q     <= signal;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            pre_q       <= tick ? 20'd0 : pre_q + 20'd1;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            mode_q      <= mode;
            pend_q      <= pend_d;
            led_q       <= led_d;
            for (int unsigned i = 0; i < CHANNELS; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (mode[2*i +: 2] == ModeAct && state_q[i] != StIdle) busy = 1'b1;
        end
    end

    assign led = led_q;

endmodule
